// File: rtl/proc_pkg.sv
// Shared types and widths for the accumulator/register-file stage and decode.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package proc_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int NREGS  = 1 << REG_AW;

  // Write-back opcode, shared with the decode stage.
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ALU  = 3'd1,
    OP_A2R  = 3'd2,
    OP_R2A  = 3'd3,
    OP_LDI  = 3'd4,
    OP_SWAP = 3'd5,
    OP_CLRC = 3'd6,
    OP_SETC = 3'd7
  } wb_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWAP2 = 1'b1
  } swap_state_t;

endpackage

// File: rtl/acc_regfile_if.sv
// Bundle between decode/control, the ALU and the architectural state stage.
// Latency: n/a (wires only).
// Backpressure: busy from the state stage stalls op_valid; upstream holds its op.
// Ports: op_valid/op/reg_addr/imm (upstream -> stage), busy (stage -> upstream),
//        acc_o/reg_o/carry_o/ovf_o/zero_o (stage -> ALU), alu_rslt/alu_sc/alu_ovf (ALU -> stage).
interface acc_regfile_if #(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int REG_AW = proc_pkg::REG_AW
);

  logic                  op_valid;
  proc_pkg::wb_op_t      op;
  logic [REG_AW-1:0]     reg_addr;
  logic [DATA_W-1:0]     imm;
  logic                  busy;
  logic [DATA_W-1:0]     acc_o;
  logic [DATA_W-1:0]     reg_o;
  logic                  carry_o;
  logic                  ovf_o;
  logic                  zero_o;
  logic [DATA_W-1:0]     alu_rslt;
  logic                  alu_sc;
  logic                  alu_ovf;

  // Upstream side: decode/control plus the ALU feeding results back.
  modport master (
    output op_valid, op, reg_addr, imm, alu_rslt, alu_sc, alu_ovf,
    input  busy, acc_o, reg_o, carry_o, ovf_o, zero_o
  );

  // State-stage side.
  modport slave (
    input  op_valid, op, reg_addr, imm, alu_rslt, alu_sc, alu_ovf,
    output busy, acc_o, reg_o, carry_o, ovf_o, zero_o
  );

endinterface

// File: rtl/acc_regfile_reg_bank.sv
// NREGS x DATA_W general register array: one async read port, one sync write port.
// Latency: read combinational; write visible after the clock edge.
// Backpressure: none; a write is taken whenever we is high.
// Ports: clk, rst_n (async clear), we/waddr/wdata (write), raddr/rdata (read).
module reg_bank #(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int REG_AW = proc_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int NREGS = 1 << REG_AW;

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // No write bypass: readers always see the pre-edge contents.
  assign rdata = regs[raddr];

endmodule

// File: rtl/acc_regfile.sv
// Architectural state around the ALU: accumulator, register bank, carry/overflow flags.
// Latency: ops commit on the accepting edge; SWAP takes two edges.
// Backpressure: busy is high during the SWAP second cycle; ops presented then are ignored.
// Ports: clk, rst_n (async active-low), bus (acc_regfile_if.slave).
module acc_regfile #(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int REG_AW = proc_pkg::REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  acc_regfile_if.slave  bus
);

  import proc_pkg::*;

  swap_state_t         state, state_nxt;
  logic [DATA_W-1:0]   acc, acc_nxt;
  logic [DATA_W-1:0]   tmp, tmp_nxt;
  logic [REG_AW-1:0]   swap_addr, swap_addr_nxt;
  logic                carry, carry_nxt;
  logic                ovf, ovf_nxt;

  logic                rf_we;
  logic [REG_AW-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [DATA_W-1:0]   rf_rdata;

  reg_bank #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (bus.reg_addr),
    .rdata (rf_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      tmp       <= '0;
      swap_addr <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      tmp       <= tmp_nxt;
      swap_addr <= swap_addr_nxt;
      carry     <= carry_nxt;
      ovf       <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    tmp_nxt       = tmp;
    swap_addr_nxt = swap_addr;
    carry_nxt     = carry;
    ovf_nxt       = ovf;
    rf_we         = 1'b0;
    rf_waddr      = bus.reg_addr;
    rf_wdata      = acc;
    bus.busy      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.op_valid) begin
          case (bus.op)
            OP_NOP: ;
            OP_ALU: begin
              acc_nxt   = bus.alu_rslt;
              carry_nxt = bus.alu_sc;
              ovf_nxt   = bus.alu_ovf;
            end
            OP_A2R: rf_we = 1'b1;
            OP_R2A: acc_nxt = rf_rdata;
            OP_LDI: acc_nxt = bus.imm;
            OP_SWAP: begin
              // First half: park the old acc, pull the register in.
              tmp_nxt       = acc;
              acc_nxt       = rf_rdata;
              swap_addr_nxt = bus.reg_addr;
              state_nxt     = SWAP2;
            end
            OP_CLRC: carry_nxt = 1'b0;
            OP_SETC: carry_nxt = 1'b1;
            default: ;
          endcase
        end
      end
      SWAP2: begin
        // Second half owns the write port; upstream is stalled so no A2R can collide.
        bus.busy  = 1'b1;
        rf_we     = 1'b1;
        rf_waddr  = swap_addr;
        rf_wdata  = tmp;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.acc_o   = acc;
  assign bus.reg_o   = rf_rdata;
  assign bus.carry_o = carry;
  assign bus.ovf_o   = ovf;
  assign bus.zero_o  = (acc == '0);

endmodule

// File: tb/tb_acc_regfile.sv
// Self-checking bench for acc_regfile: directed scenarios plus random ops
// compared every cycle against a behavioural model of the architectural state.
module tb_acc_regfile;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_regfile_if bus ();

  acc_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state plus a pending "restore register" from a SWAP.
  logic [7:0] m_acc;
  logic [7:0] m_reg [8];
  logic       m_c;
  logic       m_v;
  bit         m_pend;
  int         m_pend_addr;
  logic [7:0] m_pend_val;

  function automatic void m_reset();
    m_acc  = 8'h00;
    m_c    = 1'b0;
    m_v    = 1'b0;
    m_pend = 1'b0;
    m_pend_addr = 0;
    m_pend_val  = 8'h00;
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else if (m_pend) begin
      m_reg[m_pend_addr] = m_pend_val;
      m_pend = 1'b0;
    end else if (bus.op_valid) begin
      case (int'(bus.op))
        1: begin m_acc = bus.alu_rslt; m_c = bus.alu_sc; m_v = bus.alu_ovf; end
        2: m_reg[bus.reg_addr] = m_acc;
        3: m_acc = m_reg[bus.reg_addr];
        4: m_acc = bus.imm;
        5: begin
          m_pend_val  = m_acc;
          m_pend_addr = int'(bus.reg_addr);
          m_acc       = m_reg[bus.reg_addr];
          m_pend      = 1'b1;
        end
        6: m_c = 1'b0;
        7: m_c = 1'b1;
        default: ;
      endcase
    end
  end

  // Compare process: outputs are stable mid-cycle; inputs change at posedge+2.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("acc_o",   32'(bus.acc_o),   32'(m_acc));
      chk("reg_o",   32'(bus.reg_o),   32'(m_reg[bus.reg_addr]));
      chk("carry_o", 32'(bus.carry_o), 32'(m_c));
      chk("ovf_o",   32'(bus.ovf_o),   32'(m_v));
      chk("zero_o",  32'(bus.zero_o),  32'(m_acc == 8'h00));
      chk("busy",    32'(bus.busy),    32'(m_pend));
    end
  end

  task automatic do_op(input wb_op_t op, input int addr, input logic [7:0] imm);
    @(posedge clk);
    #2;
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.reg_addr = 3'(addr);
    bus.imm      = imm;
  endtask

  task automatic nop(input int addr);
    @(posedge clk);
    #2;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.reg_addr = 3'(addr);
  endtask

  initial begin
    m_reset();
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.reg_addr = 3'd0;
    bus.imm      = 8'h00;
    bus.alu_rslt = 8'h00;
    bus.alu_sc   = 1'b0;
    bus.alu_ovf  = 1'b0;

    // Reset state.
    #12;
    chk("rst_acc",   32'(bus.acc_o),   32'h00);
    chk("rst_reg",   32'(bus.reg_o),   32'h00);
    chk("rst_carry", 32'(bus.carry_o), 32'h0);
    chk("rst_ovf",   32'(bus.ovf_o),   32'h0);
    chk("rst_busy",  32'(bus.busy),    32'h0);
    chk("rst_zero",  32'(bus.zero_o),  32'h1);
    @(posedge clk); #2; rst_n = 1'b1;

    // LDI / A2R / LDI 0.
    do_op(OP_LDI, 0, 8'h5A);
    do_op(OP_A2R, 3, 8'h00);
    do_op(OP_LDI, 0, 8'h00);
    nop(3);
    chk("ldi0_acc",  32'(bus.acc_o),  32'h00);
    chk("ldi0_zero", 32'(bus.zero_o), 32'h1);
    chk("a2r_reg3",  32'(bus.reg_o),  32'h5A);

    // ALU commit, then CLRC leaves ovf alone.
    bus.alu_rslt = 8'h01; bus.alu_sc = 1'b1; bus.alu_ovf = 1'b1;
    do_op(OP_ALU, 0, 8'h00);
    nop(0);
    chk("alu_acc",   32'(bus.acc_o),   32'h01);
    chk("alu_carry", 32'(bus.carry_o), 32'h1);
    chk("alu_ovf",   32'(bus.ovf_o),   32'h1);
    do_op(OP_CLRC, 0, 8'h00);
    nop(0);
    chk("clrc_carry", 32'(bus.carry_o), 32'h0);
    chk("clrc_ovf",   32'(bus.ovf_o),   32'h1);

    // SWAP acc=0x11 with reg[2]=0x22.
    do_op(OP_LDI, 0, 8'h22);
    do_op(OP_A2R, 2, 8'h00);
    do_op(OP_LDI, 0, 8'h11);
    do_op(OP_SWAP, 2, 8'h00);
    nop(2);
    chk("swap1_acc",  32'(bus.acc_o), 32'h22);
    chk("swap1_busy", 32'(bus.busy),  32'h1);
    nop(2);
    chk("swap2_reg",  32'(bus.reg_o), 32'h11);
    chk("swap2_busy", 32'(bus.busy),  32'h0);

    // SWAP then LDI held through busy (acc=0x22, reg[2]=0x11 now).
    do_op(OP_SWAP, 2, 8'h00);
    do_op(OP_LDI, 2, 8'hFF);
    chk("hold_busy", 32'(bus.busy),  32'h1);
    @(posedge clk); #2;
    chk("hold_acc_unchanged", 32'(bus.acc_o), 32'h11);
    chk("hold_busy_fell",     32'(bus.busy),  32'h0);
    nop(2);
    chk("hold_ldi_acc", 32'(bus.acc_o), 32'hFF);
    chk("hold_reg2",    32'(bus.reg_o), 32'h22);

    // Reset during SWAP2.
    do_op(OP_LDI, 0, 8'h22);
    do_op(OP_A2R, 2, 8'h00);
    do_op(OP_LDI, 0, 8'h11);
    do_op(OP_SETC, 0, 8'h00);
    do_op(OP_SWAP, 2, 8'h00);
    nop(2);
    chk("mid_busy", 32'(bus.busy),  32'h1);
    chk("mid_acc",  32'(bus.acc_o), 32'h22);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_acc",   32'(bus.acc_o),   32'h00);
    chk("arst_reg2",  32'(bus.reg_o),   32'h00);
    chk("arst_busy",  32'(bus.busy),    32'h0);
    chk("arst_carry", 32'(bus.carry_o), 32'h0);
    chk("arst_ovf",   32'(bus.ovf_o),   32'h0);
    @(posedge clk); #2; rst_n = 1'b1;

    // Same-cycle read/write on A2R: no bypass.
    do_op(OP_LDI, 5, 8'h7E);
    do_op(OP_A2R, 5, 8'h00);
    chk("a2r_pre",  32'(bus.reg_o), 32'h00);
    nop(5);
    chk("a2r_post", 32'(bus.reg_o), 32'h7E);

    // Back-to-back SWAP on the same address restores both values.
    do_op(OP_LDI, 0, 8'h44);
    do_op(OP_A2R, 1, 8'h00);
    do_op(OP_LDI, 0, 8'h55);
    do_op(OP_SWAP, 1, 8'h00);
    @(posedge clk); #2;
    @(posedge clk); #2;
    @(posedge clk); #2;
    nop(1);
    chk("b2b_acc",  32'(bus.acc_o), 32'h55);
    chk("b2b_reg1", 32'(bus.reg_o), 32'h44);
    chk("b2b_busy", 32'(bus.busy),  32'h0);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      bus.op_valid = 1'($urandom_range(0, 3) != 0);
      bus.op       = wb_op_t'(3'($urandom_range(0, 7)));
      bus.reg_addr = 3'($urandom_range(0, 7));
      bus.imm      = 8'($urandom);
      bus.alu_rslt = 8'($urandom);
      bus.alu_sc   = 1'($urandom);
      bus.alu_ovf  = 1'($urandom);
    end
    nop(0);
    @(posedge clk); #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
